// File: rtl/dm_ring_controller.sv
// rtl/dm_ring_controller.sv - AXI DataMover command/status sequencer: S2MM buffer ring plus MM2S single-buffer readback
module dm_ring_controller #(
    parameter int          ADDR_W    = 32,
    parameter int          BTT_W     = 23,
    parameter int          BUF_BYTES = 4096,
    parameter int          NUM_BUF   = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        loop,
    input  logic        stop,
    output logic        busy,
    output logic        done,
    output logic        buf_done,
    output logic [3:0]  last_buf,
    output logic [15:0] wrap_count,
    input  logic        rd_start,
    input  logic [3:0]  rd_buf,
    output logic        rd_busy,
    output logic        rd_done,
    output logic        err,
    output logic [7:0]  err_sts,
    output logic        m_axis_s2mm_cmdsts_aresetn,
    output logic        m_axis_mm2s_cmdsts_aresetn,
    output logic [71:0] S_AXIS_S2MM_CMD_tdata,
    output logic        S_AXIS_S2MM_CMD_tvalid,
    input  logic        S_AXIS_S2MM_CMD_tready,
    input  logic [7:0]  M_AXIS_S2MM_STS_tdata,
    input  logic        M_AXIS_S2MM_STS_tkeep,
    input  logic        M_AXIS_S2MM_STS_tlast,
    input  logic        M_AXIS_S2MM_STS_tvalid,
    output logic        M_AXIS_S2MM_STS_tready,
    output logic [71:0] S_AXIS_MM2S_CMD_tdata,
    output logic        S_AXIS_MM2S_CMD_tvalid,
    input  logic        S_AXIS_MM2S_CMD_tready,
    input  logic [7:0]  M_AXIS_MM2S_STS_tdata,
    input  logic        M_AXIS_MM2S_STS_tkeep,
    input  logic        M_AXIS_MM2S_STS_tlast,
    input  logic        M_AXIS_MM2S_STS_tvalid,
    output logic        M_AXIS_MM2S_STS_tready
);
    typedef enum logic [1:0] {S_IDLE, S_CMD, S_WAIT, S_HALT} s2mm_state_t;
    typedef enum logic [1:0] {R_IDLE, R_CMD, R_WAIT} mm2s_state_t;

    s2mm_state_t r_state, w_state_nxt;
    mm2s_state_t r_rd_state, w_rd_state_nxt;

    logic [1:0]  r_rst_sync;
    logic [3:0]  r_idx, w_idx_inc;
    logic        r_loop, r_stop_pend;
    logic [15:0] r_wrap;
    logic [3:0]  r_last_buf;
    logic        r_buf_done, r_done, r_rd_done;
    logic        r_err;
    logic [7:0]  r_err_sts;
    logic [71:0] r_s2mm_cmd, r_mm2s_cmd;

    logic w_start_ok, w_buf_good, w_buf_bad, w_done;
    logic w_rd_accept, w_rd_badidx, w_rd_sts, w_rd_bad;
    logic w_last_idx, w_finish, w_err_base;
    logic w_unused_sts;

    function automatic logic [71:0] f_cmd(input logic [3:0] idx);
        logic [ADDR_W-1:0] a;
        a = ADDR_W'(BASE_ADDR) + ADDR_W'(idx) * ADDR_W'(BUF_BYTES);
        return {4'b0, idx, a, 8'b0, 1'b1, BTT_W'(BUF_BYTES)};
    endfunction

    function automatic logic f_bad(input logic [7:0] s);
        return !s[7] || (|s[6:4]);
    endfunction

    assign w_unused_sts = &{M_AXIS_S2MM_STS_tkeep, M_AXIS_S2MM_STS_tlast,
                            M_AXIS_MM2S_STS_tkeep, M_AXIS_MM2S_STS_tlast};

    assign w_last_idx = (r_idx == 4'(NUM_BUF - 1));
    assign w_idx_inc  = w_last_idx ? 4'd0 : r_idx + 4'd1;
    assign w_finish   = r_stop_pend || stop || (!r_loop && w_last_idx);
    assign w_rd_bad   = f_bad(M_AXIS_MM2S_STS_tdata);

    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        w_buf_good  = 1'b0;
        w_buf_bad   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    w_start_ok  = 1'b1;
                    w_state_nxt = S_CMD;
                end
            end
            S_CMD: if (S_AXIS_S2MM_CMD_tready) w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (M_AXIS_S2MM_STS_tvalid) begin
                    if (f_bad(M_AXIS_S2MM_STS_tdata)) begin
                        w_buf_bad   = 1'b1;
                        w_state_nxt = S_HALT;
                    end else begin
                        w_buf_good  = 1'b1;
                        w_state_nxt = S_CMD;
                        if (w_finish) begin
                            w_done      = 1'b1;
                            w_state_nxt = S_IDLE;
                            // Status is processed first, so the sequence is already idle and a coincident start may restart it
                            if (start) begin
                                w_start_ok  = 1'b1;
                                w_state_nxt = S_CMD;
                            end
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_rd_accept    = 1'b0;
        w_rd_badidx    = 1'b0;
        w_rd_sts       = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                if (rd_start) begin
                    if ({1'b0, rd_buf} >= 5'(NUM_BUF)) begin
                        w_rd_badidx = 1'b1;
                    end else begin
                        w_rd_accept    = 1'b1;
                        w_rd_state_nxt = R_CMD;
                    end
                end
            end
            R_CMD: if (S_AXIS_MM2S_CMD_tready) w_rd_state_nxt = R_WAIT;
            R_WAIT: begin
                if (M_AXIS_MM2S_STS_tvalid) begin
                    w_rd_sts       = 1'b1;
                    w_rd_state_nxt = R_IDLE;
                end
            end
            default: w_rd_state_nxt = R_IDLE;
        endcase
    end

    assign w_err_base = w_start_ok ? 1'b0 : r_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_sync  <= 2'b00;
            r_state     <= S_IDLE;
            r_rd_state  <= R_IDLE;
            r_idx       <= 4'd0;
            r_loop      <= 1'b0;
            r_stop_pend <= 1'b0;
            r_wrap      <= 16'd0;
            r_last_buf  <= 4'd0;
            r_buf_done  <= 1'b0;
            r_done      <= 1'b0;
            r_rd_done   <= 1'b0;
            r_err       <= 1'b0;
            r_err_sts   <= 8'd0;
            r_s2mm_cmd  <= 72'd0;
            r_mm2s_cmd  <= 72'd0;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
            r_state    <= w_state_nxt;
            r_rd_state <= w_rd_state_nxt;
            r_buf_done <= w_buf_good;
            r_done     <= w_done;
            r_rd_done  <= w_rd_sts;
            if (w_buf_good) r_last_buf <= r_idx;
            if (w_start_ok) begin
                r_idx       <= 4'd0;
                r_wrap      <= 16'd0;
                r_loop      <= loop;
                r_stop_pend <= 1'b0;
                r_s2mm_cmd  <= f_cmd(4'd0);
            end else begin
                if (stop && (r_state == S_CMD || r_state == S_WAIT)) r_stop_pend <= 1'b1;
                if (w_buf_good) begin
                    r_idx      <= w_idx_inc;
                    r_s2mm_cmd <= f_cmd(w_idx_inc);
                    if (w_last_idx && r_wrap != 16'hFFFF) r_wrap <= r_wrap + 16'd1;
                end
            end
            if (w_rd_accept) r_mm2s_cmd <= f_cmd(rd_buf);
            r_err <= w_err_base || w_buf_bad || w_rd_badidx || (w_rd_sts && w_rd_bad);
            // Only the first error since the last start is recorded; S2MM wins a same-cycle tie
            if (!w_err_base) begin
                if (w_buf_bad)                r_err_sts <= M_AXIS_S2MM_STS_tdata;
                else if (w_rd_sts && w_rd_bad) r_err_sts <= M_AXIS_MM2S_STS_tdata;
                else if (w_rd_badidx)         r_err_sts <= 8'h10;
            end
        end
    end

    assign busy                       = (r_state != S_IDLE);
    assign done                       = r_done;
    assign buf_done                   = r_buf_done;
    assign last_buf                   = r_last_buf;
    assign wrap_count                 = r_wrap;
    assign rd_busy                    = (r_rd_state != R_IDLE);
    assign rd_done                    = r_rd_done;
    assign err                        = r_err;
    assign err_sts                    = r_err_sts;
    assign m_axis_s2mm_cmdsts_aresetn = r_rst_sync[1];
    assign m_axis_mm2s_cmdsts_aresetn = r_rst_sync[1];
    assign S_AXIS_S2MM_CMD_tdata      = r_s2mm_cmd;
    assign S_AXIS_S2MM_CMD_tvalid     = (r_state == S_CMD);
    assign M_AXIS_S2MM_STS_tready     = 1'b1;
    assign S_AXIS_MM2S_CMD_tdata      = r_mm2s_cmd;
    assign S_AXIS_MM2S_CMD_tvalid     = (r_rd_state == R_CMD);
    assign M_AXIS_MM2S_STS_tready     = 1'b1;
endmodule

// File: tb/tb_dm_ring_controller.sv
// tb/tb_dm_ring_controller.sv - directed self-checking bench for dm_ring_controller
module tb_dm_ring_controller;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0, loop = 1'b0, stop = 1'b0;
    logic        busy, done, buf_done, rd_busy, rd_done, err;
    logic [3:0]  last_buf;
    logic [15:0] wrap_count;
    logic        rd_start = 1'b0;
    logic [3:0]  rd_buf = 4'd0;
    logic [7:0]  err_sts;
    logic        s2mm_aresetn, mm2s_aresetn;
    logic [71:0] s2mm_cmd_tdata, mm2s_cmd_tdata;
    logic        s2mm_cmd_tvalid, mm2s_cmd_tvalid;
    logic        s2mm_cmd_tready = 1'b1, mm2s_cmd_tready = 1'b1;
    logic [7:0]  s2mm_sts_tdata = 8'd0, mm2s_sts_tdata = 8'd0;
    logic        s2mm_sts_tvalid = 1'b0, mm2s_sts_tvalid = 1'b0;
    logic        s2mm_sts_tready, mm2s_sts_tready;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dm_ring_controller dut (
        .clk(clk), .reset_n(reset_n), .start(start), .loop(loop), .stop(stop),
        .busy(busy), .done(done), .buf_done(buf_done), .last_buf(last_buf),
        .wrap_count(wrap_count), .rd_start(rd_start), .rd_buf(rd_buf),
        .rd_busy(rd_busy), .rd_done(rd_done), .err(err), .err_sts(err_sts),
        .m_axis_s2mm_cmdsts_aresetn(s2mm_aresetn),
        .m_axis_mm2s_cmdsts_aresetn(mm2s_aresetn),
        .S_AXIS_S2MM_CMD_tdata(s2mm_cmd_tdata), .S_AXIS_S2MM_CMD_tvalid(s2mm_cmd_tvalid),
        .S_AXIS_S2MM_CMD_tready(s2mm_cmd_tready),
        .M_AXIS_S2MM_STS_tdata(s2mm_sts_tdata), .M_AXIS_S2MM_STS_tkeep(1'b1),
        .M_AXIS_S2MM_STS_tlast(1'b1), .M_AXIS_S2MM_STS_tvalid(s2mm_sts_tvalid),
        .M_AXIS_S2MM_STS_tready(s2mm_sts_tready),
        .S_AXIS_MM2S_CMD_tdata(mm2s_cmd_tdata), .S_AXIS_MM2S_CMD_tvalid(mm2s_cmd_tvalid),
        .S_AXIS_MM2S_CMD_tready(mm2s_cmd_tready),
        .M_AXIS_MM2S_STS_tdata(mm2s_sts_tdata), .M_AXIS_MM2S_STS_tkeep(1'b1),
        .M_AXIS_MM2S_STS_tlast(1'b1), .M_AXIS_MM2S_STS_tvalid(mm2s_sts_tvalid),
        .M_AXIS_MM2S_STS_tready(mm2s_sts_tready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_s2mm_valid(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (s2mm_cmd_tvalid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic send_s2mm_sts(input logic [7:0] s);
        s2mm_sts_tdata = s;
        s2mm_sts_tvalid = 1'b1;
        tick();
        s2mm_sts_tvalid = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        checks++; if (s2mm_aresetn !== 1'b0 || mm2s_aresetn !== 1'b0) begin failures++; $display("FAIL rst_aresetn_low got=%b%b exp=00", s2mm_aresetn, mm2s_aresetn); end
        checks++; if ({busy, done, buf_done, rd_busy, rd_done, err, s2mm_cmd_tvalid, mm2s_cmd_tvalid} !== 8'd0) begin failures++; $display("FAIL rst_flags got=%b exp=0", {busy, done, buf_done, rd_busy, rd_done, err, s2mm_cmd_tvalid, mm2s_cmd_tvalid}); end
        checks++; if ({last_buf, wrap_count, err_sts} !== 28'd0 || s2mm_cmd_tdata !== 72'd0) begin failures++; $display("FAIL rst_values got=%h exp=0", {last_buf, wrap_count, err_sts}); end
        reset_n = 1'b1;
        tick();
        checks++; if (s2mm_aresetn !== 1'b0) begin failures++; $display("FAIL rst_release_1clk got=%b exp=0", s2mm_aresetn); end
        tick();
        checks++; if (s2mm_aresetn !== 1'b1 || mm2s_aresetn !== 1'b1) begin failures++; $display("FAIL rst_release_2clk got=%b%b exp=11", s2mm_aresetn, mm2s_aresetn); end
    endtask

    task automatic test_single_pass();
        logic [31:0] addrs [4] = '{32'h0000, 32'h1000, 32'h2000, 32'h3000};
        logic [71:0] exp_cmd;
        bit ok;
        loop = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1 || s2mm_cmd_tvalid !== 1'b1) begin failures++; $display("FAIL single_start_latency got=%b%b exp=11", busy, s2mm_cmd_tvalid); end
        for (int i = 0; i < 4; i++) begin
            wait_s2mm_valid(ok);
            checks++; if (!ok) begin failures++; $display("FAIL single_cmd_timeout got=0 exp=1 buf=%0d", i); end
            exp_cmd = {4'b0, 4'(i), addrs[i], 8'h00, 1'b1, 23'h1000};
            checks++; if (s2mm_cmd_tdata !== exp_cmd) begin failures++; $display("FAIL single_cmd got=%h exp=%h", s2mm_cmd_tdata, exp_cmd); end
            tick();
            send_s2mm_sts(8'h80 | 8'(i));
            checks++; if (buf_done !== 1'b1 || last_buf !== 4'(i)) begin failures++; $display("FAIL single_buf_done got=%b/%0d exp=1/%0d", buf_done, last_buf, i); end
            checks++; if (done !== (i == 3)) begin failures++; $display("FAIL single_done got=%b exp=%b", done, (i == 3)); end
        end
        checks++; if (busy !== 1'b0 || wrap_count !== 16'd1 || s2mm_cmd_tvalid !== 1'b0) begin failures++; $display("FAIL single_end got=%b/%0d/%b exp=0/1/0", busy, wrap_count, s2mm_cmd_tvalid); end
        tick();
        checks++; if (done !== 1'b0 || buf_done !== 1'b0) begin failures++; $display("FAIL single_pulse_width got=%b%b exp=00", done, buf_done); end
    endtask

    task automatic test_loop_stop();
        logic [31:0] addrs [4] = '{32'h0000, 32'h1000, 32'h2000, 32'h3000};
        logic [71:0] exp_cmd;
        bit ok;
        loop = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; loop = 1'b0;
        for (int i = 0; i < 10; i++) begin
            stop = (i == 9);
            wait_s2mm_valid(ok);
            checks++; if (!ok) begin failures++; $display("FAIL loop_cmd_timeout got=0 exp=1 n=%0d", i); end
            exp_cmd = {4'b0, 4'(i % 4), addrs[i % 4], 8'h00, 1'b1, 23'h1000};
            checks++; if (s2mm_cmd_tdata !== exp_cmd) begin failures++; $display("FAIL loop_cmd got=%h exp=%h", s2mm_cmd_tdata, exp_cmd); end
            tick();
            stop = 1'b0;
            send_s2mm_sts(8'h80 | 8'(i % 4));
            checks++; if (done !== (i == 9)) begin failures++; $display("FAIL loop_done got=%b exp=%b n=%0d", done, (i == 9), i); end
        end
        checks++; if (last_buf !== 4'd1 || wrap_count !== 16'd2 || busy !== 1'b0) begin failures++; $display("FAIL loop_end got=%0d/%0d/%b exp=1/2/0", last_buf, wrap_count, busy); end
        tick();
        checks++; if (s2mm_cmd_tvalid !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL loop_halted got=%b%b exp=00", s2mm_cmd_tvalid, done); end
    endtask

    task automatic test_tready_hold();
        logic [71:0] exp_cmd = {4'b0, 4'd0, 32'h0000, 8'h00, 1'b1, 23'h1000};
        s2mm_cmd_tready = 1'b0;
        loop = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (s2mm_cmd_tvalid !== 1'b1 || s2mm_cmd_tdata !== exp_cmd) begin failures++; $display("FAIL hold_stable got=%b/%h exp=1/%h", s2mm_cmd_tvalid, s2mm_cmd_tdata, exp_cmd); end
            tick();
        end
        s2mm_cmd_tready = 1'b1;
        tick();
        checks++; if (s2mm_cmd_tvalid !== 1'b0) begin failures++; $display("FAIL hold_one_cmd got=%b exp=0", s2mm_cmd_tvalid); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++; if (s2mm_cmd_tvalid !== 1'b0) begin failures++; $display("FAIL hold_no_second got=%b exp=0", s2mm_cmd_tvalid); end
        send_s2mm_sts(8'h80);
        checks++; if (done !== 1'b1 || busy !== 1'b0 || last_buf !== 4'd0) begin failures++; $display("FAIL hold_stop_end got=%b/%b/%0d exp=1/0/0", done, busy, last_buf); end
        tick();
    endtask

    task automatic test_error_halt();
        logic [71:0] exp_cmd = {4'b0, 4'd0, 32'h0000, 8'h00, 1'b1, 23'h1000};
        bit ok;
        loop = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_s2mm_valid(ok);
            checks++; if (!ok) begin failures++; $display("FAIL err_cmd_timeout got=0 exp=1 buf=%0d", i); end
            tick();
            send_s2mm_sts(i == 2 ? 8'hC2 : 8'h80 | 8'(i));
        end
        checks++; if (err !== 1'b1 || err_sts !== 8'hC2) begin failures++; $display("FAIL err_capture got=%b/%h exp=1/c2", err, err_sts); end
        checks++; if (busy !== 1'b1 || buf_done !== 1'b0 || last_buf !== 4'd1) begin failures++; $display("FAIL err_halt_state got=%b/%b/%0d exp=1/0/1", busy, buf_done, last_buf); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (s2mm_cmd_tvalid !== 1'b0) begin failures++; $display("FAIL err_no_cmd got=%b exp=0", s2mm_cmd_tvalid); end
            tick();
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (err !== 1'b0 || s2mm_cmd_tvalid !== 1'b1 || s2mm_cmd_tdata !== exp_cmd) begin failures++; $display("FAIL err_restart got=%b/%b/%h exp=0/1/%h", err, s2mm_cmd_tvalid, s2mm_cmd_tdata, exp_cmd); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        send_s2mm_sts(8'h80);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL err_restart_end got=%b/%b exp=1/0", done, busy); end
        tick();
    endtask

    task automatic test_readback();
        logic [71:0] exp_rd = {4'b0, 4'd3, 32'h3000, 8'h00, 1'b1, 23'h1000};
        loop = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; loop = 1'b0;
        tick();
        rd_buf = 4'd3; rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        checks++; if (mm2s_cmd_tvalid !== 1'b1 || rd_busy !== 1'b1 || mm2s_cmd_tdata !== exp_rd) begin failures++; $display("FAIL rd_cmd got=%b/%b/%h exp=1/1/%h", mm2s_cmd_tvalid, rd_busy, mm2s_cmd_tdata, exp_rd); end
        tick();
        checks++; if (mm2s_cmd_tvalid !== 1'b0 || busy !== 1'b1 || s2mm_cmd_tvalid !== 1'b0) begin failures++; $display("FAIL rd_handshake got=%b/%b/%b exp=0/1/0", mm2s_cmd_tvalid, busy, s2mm_cmd_tvalid); end
        mm2s_sts_tdata = 8'h83; mm2s_sts_tvalid = 1'b1;
        tick();
        mm2s_sts_tvalid = 1'b0;
        checks++; if (rd_done !== 1'b1 || rd_busy !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL rd_done got=%b/%b/%b exp=1/0/0", rd_done, rd_busy, err); end
        tick();
        checks++; if (rd_done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL rd_done_pulse got=%b/%b exp=0/1", rd_done, busy); end
        rd_buf = 4'd7; rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        checks++; if (err !== 1'b1 || err_sts !== 8'h10 || rd_busy !== 1'b0 || mm2s_cmd_tvalid !== 1'b0) begin failures++; $display("FAIL rd_badidx got=%b/%h/%b/%b exp=1/10/0/0", err, err_sts, rd_busy, mm2s_cmd_tvalid); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        send_s2mm_sts(8'h80);
        checks++; if (done !== 1'b1 || last_buf !== 4'd0 || busy !== 1'b0) begin failures++; $display("FAIL rd_s2mm_unaffected got=%b/%0d/%b exp=1/0/0", done, last_buf, busy); end
        tick();
    endtask

    task automatic test_reset_mid();
        loop = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; loop = 1'b0;
        tick();
        checks++; if (busy !== 1'b1 || s2mm_cmd_tvalid !== 1'b0) begin failures++; $display("FAIL mid_in_wait got=%b/%b exp=1/0", busy, s2mm_cmd_tvalid); end
        reset_n = 1'b0;
        #1;
        checks++; if ({busy, done, buf_done, rd_busy, rd_done, err, s2mm_cmd_tvalid, mm2s_cmd_tvalid} !== 8'd0) begin failures++; $display("FAIL mid_flags got=%b exp=0", {busy, done, buf_done, rd_busy, rd_done, err, s2mm_cmd_tvalid, mm2s_cmd_tvalid}); end
        checks++; if (err_sts !== 8'd0 || s2mm_cmd_tdata !== 72'd0 || mm2s_cmd_tdata !== 72'd0 || s2mm_aresetn !== 1'b0 || mm2s_aresetn !== 1'b0) begin failures++; $display("FAIL mid_values got=%h/%b%b exp=00/00", err_sts, s2mm_aresetn, mm2s_aresetn); end
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        checks++; if (s2mm_aresetn !== 1'b0) begin failures++; $display("FAIL mid_release_1clk got=%b exp=0", s2mm_aresetn); end
        tick();
        checks++; if (s2mm_aresetn !== 1'b1 || mm2s_aresetn !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL mid_release_2clk got=%b%b/%b exp=11/0", s2mm_aresetn, mm2s_aresetn, busy); end
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_loop_stop();
        test_tready_hold();
        test_error_halt();
        test_readback();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dm_ring_controller.md
Name: dm_ring_controller

Overview:
- Parametrised command/status sequencer for one AXI DataMover with independent S2MM and MM2S channels.
- S2MM side writes the incoming stream into a ring of NUM_BUF equal buffers in memory, in either single-pass or continuous-loop mode.
- MM2S side issues on-demand readback of any single buffer.
- Sits between top-level control logic and the datamover command/status AXI-Stream ports; replaces hard-coded one-shot command logic.

Parameters:
- ADDR_W, 32, address field width in the command word (fixed 32 for 72-bit commands)
- BTT_W, 23, bytes-to-transfer field width
- BUF_BYTES, 4096, bytes per buffer; must be a multiple of 8 and < 2**BTT_W
- NUM_BUF, 4, buffers in ring, 1..16
- BASE_ADDR, 32'h0000_0000, byte address of buffer 0

Ports:
- clk  in  1  sole clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  pulse: begin S2MM capture at buffer 0
- loop  in  1  sampled at start: 1=continuous ring, 0=stop after NUM_BUF buffers
- stop  in  1  pulse: finish the current buffer then halt
- busy  out  1  S2MM sequence active
- done  out  1  one-cycle pulse when the S2MM sequence ends (normal or stopped)
- buf_done  out  1  one-cycle pulse per completed S2MM buffer
- last_buf  out  4  index of the most recently completed S2MM buffer
- wrap_count  out  16  ring wraps since start, saturating
- rd_start  in  1  pulse: read back buffer rd_buf
- rd_buf  in  4  buffer index for readback
- rd_busy  out  1  MM2S read in progress
- rd_done  out  1  one-cycle pulse on MM2S completion
- err  out  1  sticky: any error status; cleared by start
- err_sts  out  8  first error status byte captured
- m_axis_s2mm_cmdsts_aresetn  out  1  datamover S2MM cmd/status reset
- m_axis_mm2s_cmdsts_aresetn  out  1  datamover MM2S cmd/status reset
- S_AXIS_S2MM_CMD_tdata/tvalid/tready  out/out/in  72/1/1  S2MM command
- M_AXIS_S2MM_STS_tdata/tkeep/tlast/tvalid/tready  in/in/in/in/out  8/1/1/1/1  S2MM status
- S_AXIS_MM2S_CMD_tdata/tvalid/tready  out/out/in  72/1/1  MM2S command
- M_AXIS_MM2S_STS_tdata/tkeep/tlast/tvalid/tready  in/in/in/in/out  8/1/1/1/1  MM2S status

Behaviour:
- Reset: every output 0 except the cmdsts_aresetn outputs, which are low while reset_n is low and go high 2 clk after reset_n rises (2-flop release synchroniser).
- Command word = {4'b0, tag, addr[31:0], 8'b0, 1'b1 (INCR), BUF_BYTES[22:0]}.
  - addr = BASE_ADDR + idx*BUF_BYTES
  - tag = idx[3:0]
  - tdata is registered and held stable while tvalid is high.
- STS tready is tied 1 on both channels; a status beat is accepted whenever tvalid=1.
- Status decode: error if bit7 (OKAY)=0 or any of bits 6:4 (SLVERR, DECERR, INTERR) is set.
- S2MM FSM states: IDLE, CMD, WAIT_STS, HALT_ERR.
  - IDLE: on start, set idx=0, wrap_count=0, clear err, latch loop, set busy=1, go to CMD.
  - CMD: tvalid=1 until the tready&tvalid cycle, then go to WAIT_STS. One command is outstanding at most.
  - WAIT_STS, good status:
    - pulse buf_done; last_buf=idx.
    - idx advances to idx+1; at NUM_BUF-1 it wraps to 0 and wrap_count increments, saturating at 16'hFFFF.
    - If a stop was seen since the last command, or loop=0 and idx was NUM_BUF-1: go to IDLE, busy=0, pulse done in the same cycle.
    - Otherwise go to CMD in the next cycle.
  - WAIT_STS, bad status: set err; err_sts=status byte if err was 0; go to HALT_ERR with busy=1. Only a new start leaves HALT_ERR; it behaves as from IDLE.
  - stop is latched into a pending flag in CMD/WAIT_STS and ignored in IDLE. A command already in flight is never withdrawn.
  - start while busy is ignored.
- MM2S FSM states: IDLE, CMD, WAIT_STS. It runs independently of S2MM.
  - IDLE: rd_start latches rd_buf and sets rd_busy. If rd_buf >= NUM_BUF, instead set err with err_sts=8'h10 (INTERR) and stay in IDLE.
  - CMD/WAIT_STS: same handshake as S2MM.
  - On status: rd_busy=0 and rd_done pulses. A bad status sets err/err_sts under the same first-capture rule.
  - rd_start while rd_busy is ignored.
- Status beat and start in the same cycle: the status is processed first, and start is honoured only if the FSM is then in IDLE or HALT_ERR.
- Latency: start to S2MM_CMD tvalid = 1 clk; status beat to next command tvalid = 1 clk.

Test Plan:
- NUM_BUF=4, loop=0, start, tready=1, good status 8'h80|tag each time -> 4 commands at addresses 0x0, 0x1000, 0x2000, 0x3000 with tags 0..3; 4 buf_done pulses; done on the 4th status; busy falls; wrap_count=1.
- loop=1, 10 good statuses, stop pulse after status 9 -> commands continue at 0x0000, 0x1000, 0x2000, 0x3000, 0x0000, ...; halts after status 10; last_buf=1; wrap_count=2; done pulses once.
- Hold CMD tready=0 for 5 clk -> tvalid stays high and tdata is unchanged; exactly one command is accepted on release.
- Status 8'hC2 (SLVERR) on buffer 2 -> err=1, err_sts=8'hC2, no further commands; start then clears err and restarts at addr 0x0.
- During S2MM capture, rd_start with rd_buf=3 -> MM2S command addr 0x3000, tag 3, BTT 0x1000; rd_done on status; S2MM sequence unaffected; rd_buf=7 -> err, err_sts=8'h10, no MM2S command.
- Assert reset_n low mid-WAIT_STS -> all outputs 0 immediately; cmdsts_aresetn stays low until 2 clk after reset_n rises.
